// File: rtl/tt_loader_pkg.sv
// Shared types for the operand loader: FSM states, the buffered pair record
// and the parity helper. The pair record carries parity bits only when
// TT_LOADER_PARITY_EN is defined.
package tt_loader_pkg;

    localparam int LOADER_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        HAVE_A = 1'b1
    } loader_state_t;

    typedef struct packed {
        logic [LOADER_WIDTH-1:0] a;
        logic [LOADER_WIDTH-1:0] b;
`ifdef TT_LOADER_PARITY_EN
        logic [1:0]              par;   // {par_b, par_a}
`endif
    } operand_pair_t;

    // Even-parity bit: set when the operand has an odd number of ones.
    function automatic logic even_par(input logic [LOADER_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/tt_operand_loader_if.sv
// Byte-input and pair-output handshake bundle of the operand loader.
// The loader takes the slave view; the producer/consumer side takes master.
interface tt_operand_loader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_strobe;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [1:0]       out_par;

    modport master (
        output in_data, in_strobe, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_par
    );

    modport slave (
        input  in_data, in_strobe, out_ready,
        output in_ready, out_valid, out_a, out_b, out_par
    );
endinterface

// File: rtl/tt_pair_fifo.sv
// DEPTH-entry synchronous FIFO of operand pairs. Head is read combinationally
// so a pair pushed at edge N is visible right after edge N; head reads as
// zero while empty. Push on a full FIFO is accepted only with a same-cycle pop.
module tt_pair_fifo
    import tt_loader_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  operand_pair_t din,
    output logic          full,
    output logic          empty,
    output operand_pair_t head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    operand_pair_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr_reg];

    // Storage: each entry is written only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the incoming pair into this slot.
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= din;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/tt_operand_loader.sv
// Operand loader: pairs A then B bytes from a shared bus, queues the pairs
// and presents them over valid/ready. Flags dropped bytes (ovf) and stale
// half-pairs discarded by the timeout (tmo).
// Optional macro TT_LOADER_PARITY_EN: store per-pair parity and drive out_par.
module tt_operand_loader
    import tt_loader_pkg::*;
#(
    parameter int WIDTH   = LOADER_WIDTH,   // pair record is sized by LOADER_WIDTH
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flag_clr,
    output logic                ovf,
    output logic                tmo,
    tt_operand_loader_if.slave  bus
);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    loader_state_t    state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [TMO_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, tmo_reg;

    logic             fifo_full, fifo_empty;
    logic             pop, push, accept, timeout_hit, tmo_set, ovf_set;
    operand_pair_t    pair_in, head;

    assign pop         = ~fifo_empty & bus.out_ready;
    assign bus.in_ready = (state_reg == IDLE) | ~fifo_full | pop;
    assign accept      = bus.in_strobe & bus.in_ready;
    assign push        = (state_reg == HAVE_A) & accept;
    assign ovf_set     = bus.in_strobe & ~bus.in_ready;
    assign timeout_hit = (TIMEOUT != 0) && (state_reg == HAVE_A) && !accept &&
                         (cnt_reg == TMO_W'(TIMEOUT - 1));

    // Pair assembly: B comes straight off the bus in the cycle it is accepted.
    always_comb begin
        pair_in   = '0;
        pair_in.a = a_reg;
        pair_in.b = bus.in_data;
`ifdef TT_LOADER_PARITY_EN
        pair_in.par = {even_par(bus.in_data), even_par(a_reg)};
`endif
    end

    // Next-state logic: capture A, then B; a B strobe beats a same-cycle timeout.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        cnt_next   = cnt_reg;
        tmo_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = HAVE_A;
                    a_next     = bus.in_data;
                    cnt_next   = '0;
                end
            end
            HAVE_A: begin
                if (accept) begin
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    tmo_set    = 1'b1;
                end else if (cnt_reg != {TMO_W{1'b1}}) begin
                    cnt_next = cnt_reg + TMO_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, held operand A and the half-pair age counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Sticky error flags; a set event in the same cycle overrides a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
            tmo_reg <= 1'b0;
        end else begin
            if (ovf_set)       ovf_reg <= 1'b1;
            else if (flag_clr) ovf_reg <= 1'b0;
            if (tmo_set)       tmo_reg <= 1'b1;
            else if (flag_clr) tmo_reg <= 1'b0;
        end
    end

    tt_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pair_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign bus.out_valid = ~fifo_empty;
    assign bus.out_a     = head.a;
    assign bus.out_b     = head.b;
`ifdef TT_LOADER_PARITY_EN
    assign bus.out_par   = head.par;
`else
    assign bus.out_par   = 2'b00;
`endif
    assign ovf           = ovf_reg;
    assign tmo           = tmo_reg;

endmodule

// File: tb/tb_tt_operand_loader.sv
// Table-driven bench for tt_operand_loader (TIMEOUT=4, DEPTH=2) plus a
// hand-written asynchronous-reset sequence.
module tb_tt_operand_loader;

    typedef struct {
        logic       strobe;
        logic [7:0] data;
        logic       out_ready;
        logic       flag_clr;
        logic       exp_in_ready;
        logic       exp_valid;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_ovf;
        logic       exp_tmo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flag_clr = 1'b0;
    logic ovf, tmo;
    int   checks = 0;
    int   failures = 0;

    tt_operand_loader_if #(.WIDTH(8)) bus ();

    tt_operand_loader #(
        .WIDTH   (8),
        .DEPTH   (2),
        .TIMEOUT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flag_clr (flag_clr),
        .ovf      (ovf),
        .tmo      (tmo),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic s, logic [7:0] d, logic orr, logic fc,
                                logic ir, logic vv, logic [7:0] ea, logic [7:0] eb,
                                logic eo, logic et);
        vec_t v;
        v.strobe = s;  v.data = d;  v.out_ready = orr;  v.flag_clr = fc;
        v.exp_in_ready = ir;  v.exp_valid = vv;  v.exp_a = ea;  v.exp_b = eb;
        v.exp_ovf = eo;  v.exp_tmo = et;
        return v;
    endfunction

    function automatic logic [1:0] exp_par(logic [7:0] a, logic [7:0] b);
`ifdef TT_LOADER_PARITY_EN
        return {^b, ^a};
`else
        return 2'b00;
`endif
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec%0d got=%0h exp=%0h", name, idx, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check ready before the edge, outputs after it.
    task automatic run_vec(input vec_t v, input int idx);
        bus.in_strobe = v.strobe;
        bus.in_data   = v.data;
        bus.out_ready = v.out_ready;
        flag_clr      = v.flag_clr;
        #1;
        chk("in_ready", idx, 32'(bus.in_ready), 32'(v.exp_in_ready));
        @(posedge clk);
        #1;
        chk("out_valid", idx, 32'(bus.out_valid), 32'(v.exp_valid));
        chk("out_a", idx, 32'(bus.out_a), 32'(v.exp_a));
        chk("out_b", idx, 32'(bus.out_b), 32'(v.exp_b));
        chk("out_par", idx, 32'(bus.out_par), 32'(exp_par(v.exp_a, v.exp_b)));
        chk("ovf", idx, 32'(ovf), 32'(v.exp_ovf));
        chk("tmo", idx, 32'(tmo), 32'(v.exp_tmo));
        $display("vec%0d strobe=%0b data=%02h rdy=%0b -> valid=%0b a=%02h b=%02h par=%0b ovf=%0b tmo=%0b",
                 idx, v.strobe, v.data, v.out_ready, bus.out_valid, bus.out_a, bus.out_b,
                 bus.out_par, ovf, tmo);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t rtbl[$];

        bus.in_strobe = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // T1: single pair through with consumer ready
        tbl.push_back(mk(1, 8'hF0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h3C, 1, 0, 1, 1, 8'hF0, 8'h3C, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        // T2: fill FIFO, drop 3rd B (set beats clear), extra strobe dropped
        tbl.push_back(mk(1, 8'h11, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 1, 1, 8'h11, 8'h12, 0, 0));
        tbl.push_back(mk(1, 8'h21, 0, 0, 1, 1, 8'h11, 8'h12, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 0, 1, 1, 8'h11, 8'h12, 0, 0));
        tbl.push_back(mk(1, 8'h31, 0, 0, 1, 1, 8'h11, 8'h12, 0, 0));
        tbl.push_back(mk(1, 8'h32, 0, 1, 0, 1, 8'h11, 8'h12, 1, 0));
        tbl.push_back(mk(1, 8'h33, 0, 0, 0, 1, 8'h11, 8'h12, 1, 0));
        // T4: full FIFO, pop and B in the same cycle -> accepted, lands last
        tbl.push_back(mk(1, 8'h32, 1, 0, 1, 1, 8'h21, 8'h22, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h21, 8'h22, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h31, 8'h32, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0));
        // T3: A=55 then 4 idle cycles -> timeout, then clean pair
        tbl.push_back(mk(1, 8'h55, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(1, 8'h11, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(1, 8'h22, 1, 0, 1, 1, 8'h11, 8'h22, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0));
        // B strobe in the very cycle the timeout would fire -> capture wins
        tbl.push_back(mk(1, 8'h66, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h77, 1, 0, 1, 1, 8'h66, 8'h77, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        // T6: parity pair {07,03}
        tbl.push_back(mk(1, 8'h07, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h03, 1, 0, 1, 1, 8'h07, 8'h03, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));

        // T5 setup: one pair queued and A=03 held when reset hits
        rtbl.push_back(mk(1, 8'h01, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        rtbl.push_back(mk(1, 8'h02, 0, 0, 1, 1, 8'h01, 8'h02, 0, 0));
        rtbl.push_back(mk(1, 8'h03, 0, 0, 1, 1, 8'h01, 8'h02, 0, 0));
        // T5 after release: new pair must not pair with the stale A
        rtbl.push_back(mk(1, 8'h0A, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        rtbl.push_back(mk(1, 8'h0B, 0, 0, 1, 1, 8'h0A, 8'h0B, 0, 0));
        rtbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0));

        // Reset state
        #2;
        chk("rst_valid", -1, 32'(bus.out_valid), 32'd0);
        chk("rst_a", -1, 32'(bus.out_a), 32'd0);
        chk("rst_b", -1, 32'(bus.out_b), 32'd0);
        chk("rst_par", -1, 32'(bus.out_par), 32'd0);
        chk("rst_ready", -1, 32'(bus.in_ready), 32'd1);
        chk("rst_ovf", -1, 32'(ovf), 32'd0);
        chk("rst_tmo", -1, 32'(tmo), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // T5: asynchronous reset mid-pair with a queued pair
        for (int i = 0; i < 3; i++) run_vec(rtbl[i], 100 + i);
        bus.in_strobe = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 200, 32'(bus.out_valid), 32'd0);
        chk("arst_a", 200, 32'(bus.out_a), 32'd0);
        chk("arst_b", 200, 32'(bus.out_b), 32'd0);
        chk("arst_par", 200, 32'(bus.out_par), 32'd0);
        chk("arst_ready", 200, 32'(bus.in_ready), 32'd1);
        $display("async reset: valid=%0b a=%02h b=%02h ready=%0b",
                 bus.out_valid, bus.out_a, bus.out_b, bus.in_ready);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 3; i < 6; i++) run_vec(rtbl[i], 100 + i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
